// File: rtl/pipelined_zext_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_zext_adder
// Purpose  : A + ext(B) with the carry chain cut into STAGES registered chunks;
//            operands skew in, result chunks deskew out, valid/ready on both sides.
// Options  : define SIGN_EXT_EN to add b_signed (sign-extend b when set).
// Revision : 1.0
// ============================================================================
module pipelined_zext_adder #(
    parameter int WA     = 56,
    parameter int WB     = 37,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
`ifdef SIGN_EXT_EN
    input  logic          b_signed,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WA:0]   sum
);

    localparam int CW     = (WA + STAGES - 1) / STAGES;
    localparam int LAST_W = WA - (STAGES - 1) * CW;

    if (WB < 1 || WB > WA) begin : g_bad_wb
        $error("pipelined_zext_adder: WB must lie in 1..WA");
    end
    if (STAGES < 1 || STAGES > WA) begin : g_bad_stages
        $error("pipelined_zext_adder: STAGES must lie in 1..WA");
    end
    if (LAST_W < 1) begin : g_bad_last
        $error("pipelined_zext_adder: last chunk width must be at least 1");
    end

    logic          w_adv;
    logic          w_fill;
    logic [WA-1:0] w_bext;

    // Global stall: every stage moves together, so bubbles are preserved.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

`ifdef SIGN_EXT_EN
    assign w_fill = b_signed & b[WB-1];
`else
    assign w_fill = 1'b0;
`endif

    if (WB < WA) begin : g_ext
        assign w_bext = {{(WA-WB){w_fill}}, b};
    end else begin : g_noext
        assign w_bext = b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;
        localparam int HI = (k == STAGES - 1) ? WA : (k + 1) * CW;
        localparam int W  = HI - LO;

        logic [W-1:0]  w_op_a;
        logic [W-1:0]  w_op_b;
        logic          w_cin;
        logic          w_vin;
        logic [W:0]    w_sum;
        logic [HI-1:0] res_d;
        logic [HI-1:0] res_q;
        logic          carry_q;
        logic          valid_q;

        if (k == 0) begin : g_head
            assign w_op_a = a[HI-1:0];
            assign w_op_b = w_bext[HI-1:0];
            assign w_cin  = 1'b0;
            assign w_vin  = in_valid;
            assign res_d  = w_sum[W-1:0];
        end else begin : g_body
            assign w_op_a = g_stage[k-1].g_skew.a_q[W-1:0];
            assign w_op_b = g_stage[k-1].g_skew.b_q[W-1:0];
            assign w_cin  = g_stage[k-1].carry_q;
            assign w_vin  = g_stage[k-1].valid_q;
            // Lower chunks ride along with this transaction (deskew).
            assign res_d  = {w_sum[W-1:0], g_stage[k-1].res_q};
        end

        assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {{W{1'b0}}, w_cin};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (w_adv) begin
                valid_q <= w_vin;
                carry_q <= w_sum[W];
                res_q   <= res_d;
            end
        end

        // Operand bits above this chunk wait here until their own stage.
        if (k < STAGES - 1) begin : g_skew
            logic [WA-HI-1:0] a_d;
            logic [WA-HI-1:0] b_d;
            logic [WA-HI-1:0] a_q;
            logic [WA-HI-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = a[WA-1:HI];
                assign b_d = w_bext[WA-1:HI];
            end else begin : g_src_prev
                assign a_d = g_stage[k-1].g_skew.a_q[WA-LO-1:W];
                assign b_d = g_stage[k-1].g_skew.b_q[WA-LO-1:W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (w_adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].res_q};

endmodule
`default_nettype wire

// File: doc/pipelined_zext_adder.md
Name: pipelined_zext_adder

Overview:
- Parametrised, pipelined successor to the fixed 56+37-bit zero-extending adder in the multiply/accumulate datapath.
- Adds a WA-bit operand to a WB-bit operand, with WB <= WA, zero-extended by default.
- The carry chain is split into STAGES registered chunks with operand skew and result deskew, giving one result per cycle at a higher clock rate.
- Valid/ready handshake on both sides so the block can sit between partial-product reduction and the accumulator.

Parameters:
- WA, 56, width of operand A and of the sum excluding carry-out.
- WB, 37, width of operand B; legal range 1..WA; elaboration error otherwise.
- STAGES, 4, number of pipeline stages (carry chunks); legal range 1..WA.
- CW, ceil(WA/STAGES), derived chunk width; the last chunk takes the remainder WA-(STAGES-1)*CW, which must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operands on a/b are valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WA  operand A, unsigned.
- b  in  WB  operand B, zero-extended to WA.
- out_valid  out  1  sum is valid.
- out_ready  in  1  downstream accepts sum this cycle.
- sum  out  WA+1  A + ext(B); MSB is carry-out.

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, all stage valid bits, chunk registers, carry registers and skew registers clear to 0.
  - Outputs in reset: out_valid=0, sum=0, in_ready=1 (derived from out_valid=0).
- Advance signal: adv = !out_valid | out_ready. in_ready = adv, combinational.
  - When adv=1, every stage register loads from its predecessor.
  - When adv=0, all stages hold; this is a global stall.
  - Bubbles do not collapse.
- Accept: a transfer occurs when in_valid & in_ready. Stage-0 valid loads (in_valid & adv).
  - Operand registers load only when adv=1; their data is don't-care when valid=0.
- Stage k (0..STAGES-1):
  - Adds chunk k of A, chunk k of ext(B), and the carry registered by stage k-1. Stage 0 uses carry-in 0.
  - Registers the chunk result and the carry-out.
  - Upper chunks of A/B travel through skew registers until their stage.
  - Lower result chunks travel through deskew registers so all chunks of one transaction exit together.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, provided no stalls occur. Each stall cycle adds one cycle.
- Output: sum = {final carry, chunk results}, registered. Stable while out_valid=1 and out_ready=0.
- Throughput: 1 result per cycle while out_ready=1.
- Arithmetic: modulo-free; the full WA+1-bit result is always exact.
  - Chunks of ext(B) above bit WB-1 are constant 0. Synthesis prunes them.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Boundaries:
  - A all-ones + B=1 ripples carry through every chunk and gives sum = 2^WA.
  - A=0, B=0 gives sum=0.
  - A chunk boundary at or beyond WB is handled identically to one inside it.
- Simultaneous events: a drain by out_ready and an accept by in_valid in the same cycle are both performed; no throughput loss.
- Reset mid-operation: in-flight transactions are discarded. No partial result emerges after reset deasserts.
- Handshake rules: in_valid may depend on nothing from this block. out_valid never drops without out_ready=1.

Optional Feature:
- Macro: SIGN_EXT_EN.
- Defined:
  - Adds input port b_signed (1 bit), sampled with a/b at accept and carried through the pipeline.
  - When b_signed=1, b is sign-extended from bit WB-1 to WA bits. Upper chunks of ext(B) become replicated b[WB-1].
  - Sum remains WA+1 bits: sum = A + sext(B), computed as an unsigned WA-bit addition of the two's-complement extended B.
  - The carry-out MSB is the raw adder carry.
- Undefined: no b_signed port; zero extension only; behaviour exactly as above.

Test Plan:
- Reset then single add with defaults: a=56'h00FF_FFFF_FFFF_FFFF, b=37'h1, out_ready=1 -> out_valid rises exactly 4 cycles after the accept; sum=57'h0100_0000_0000_0000.
- Full-carry ripple: a=2^56-1, b=1 -> sum=57'h1_0000_0000_0000_00 (only the MSB set); b=37'h1F_FFFF_FFFF, a=0 -> sum=57'h1F_FFFF_FFFF.
- Back-to-back stream: 16 random pairs with in_valid=1 and out_ready=1 -> 16 results on 16 consecutive cycles, in order, each matching the reference model A+B.
- Backpressure: hold out_ready=0 for 5 cycles while a result is valid -> in_ready=0, sum and out_valid held stable; after release, all queued results emerge in order with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately (asynchronous); after release, no stale result appears; a new add of 5+7 returns sum=12.
- SIGN_EXT_EN build: a=100, b=37'h1F_FFFF_FFFF (-1), b_signed=1 -> sum[55:0]=99, sum[56]=1; same inputs with b_signed=0 -> sum=100+2^37-1.
- Parameter sweep: STAGES=1, WA=8, WB=8, a=8'hFF, b=8'hFF -> sum=9'h1FE with latency 1.
